// File: rtl/div_scheduler.sv
// Two-requester arbiter around one shared unsigned restoring divider (one quotient bit per clock).
// Optional round-robin arbitration is enabled by defining DIV_SCHED_RR_EN; otherwise requester 0 has fixed priority.
module div_scheduler #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [2*WIDTH-1:0] req_dividend,
  input  logic [2*WIDTH-1:0] req_divisor,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_id,
  output logic [WIDTH-1:0]   rsp_quotient,
  output logic [WIDTH-1:0]   rsp_remainder,
  output logic               rsp_dz,
  output logic               busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic             r_id;
  logic             r_dz;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_r;
  logic [WIDTH-1:0] r_d;

  logic             w_grant;
  logic             w_accept;
  logic [WIDTH-1:0] w_dvd;
  logic [WIDTH-1:0] w_dvs;
  logic             w_dvs_zero;
  logic [WIDTH:0]   w_r_sh;
  logic [WIDTH-1:0] w_r_diff;
  logic             w_ge;

`ifdef DIV_SCHED_RR_EN
  logic r_ptr;

  // r_ptr = 1 means requester 1 is preferred; the grant only matters when some request is valid.
  assign w_grant = r_ptr ? req_valid[1] : ~req_valid[0];
`else
  assign w_grant = ~req_valid[0];
`endif

  assign w_dvd      = w_grant ? req_dividend[2*WIDTH-1:WIDTH] : req_dividend[WIDTH-1:0];
  assign w_dvs      = w_grant ? req_divisor[2*WIDTH-1:WIDTH]  : req_divisor[WIDTH-1:0];
  assign w_dvs_zero = (w_dvs == '0);

  // Shifted partial remainder is WIDTH+1 bits; its carry bit alone guarantees R >= D.
  // The true difference is below D, so a WIDTH-bit modular subtract is exact.
  assign w_r_sh   = {r_r, r_q[WIDTH-1]};
  assign w_ge     = w_r_sh[WIDTH] | (w_r_sh[WIDTH-1:0] >= r_d);
  assign w_r_diff = w_r_sh[WIDTH-1:0] - r_d;

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = '0;
    w_accept    = 1'b0;
    rsp_valid   = 1'b0;
    busy        = 1'b1;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (|req_valid) begin
          req_ready[w_grant] = 1'b1;
          w_accept           = 1'b1;
          w_state_nxt        = w_dvs_zero ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        if (r_cnt == CNT_W'(1)) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_id    <= 1'b0;
      r_dz    <= 1'b0;
`ifdef DIV_SCHED_RR_EN
      r_ptr   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_cnt <= CNT_W'(WIDTH);
        r_id  <= w_grant;
        r_dz  <= w_dvs_zero;
`ifdef DIV_SCHED_RR_EN
        r_ptr <= ~w_grant;
`endif
      end else if (r_state == S_CALC) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
    end
  end

  // Operand/result registers carry no reset; outputs are masked outside DONE.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      if (w_dvs_zero) begin
        r_q <= '1;
        r_r <= w_dvd;
      end else begin
        r_q <= w_dvd;
        r_r <= '0;
        r_d <= w_dvs;
      end
    end else if (r_state == S_CALC) begin
      r_r <= w_ge ? w_r_diff : w_r_sh[WIDTH-1:0];
      r_q <= {r_q[WIDTH-2:0], w_ge};
    end
  end

  assign rsp_id        = rsp_valid & r_id;
  assign rsp_dz        = rsp_valid & r_dz;
  assign rsp_quotient  = rsp_valid ? r_q : '0;
  assign rsp_remainder = rsp_valid ? r_r : '0;

endmodule
